thread_scheduler: RTL
=====================

# thread_scheduler

Round-robin fetch scheduler for the interleaved multithreading front end. Every cycle it picks the thread whose PC the IF stage fetches, using a one-hot-free round-robin over the threads that are eligible to fetch. It parks a thread while that thread has an unresolved control-flow instruction or an outstanding instruction-memory miss. The registered thread ID it produces drives the IF PC select and PC update logic, and it replaces the free-running thread counter.

## Interface
Parameters:
- N, default THREAD_POOL_SIZE (4): number of hardware threads. Fixed at 4, so thread IDs are 2 bits.

Ports:
- clk: input, 1 bit. Pipeline clock.
- rst: input, 1 bit. Reset, synchronous, active-high.
- thread_en: input, [N-1:0]. Per-thread enable, a configuration input. A thread with its bit at 0 is never selected.
- ID_br_issue: input, 1 bit. Decode found a branch or jump for thread TID_ID.
- TID_ID: input, [1:0]. Thread ID of the decoded instruction.
- EXE_br_resolve: input, 1 bit. The branch of thread TID_EXE has resolved in EXE, whether taken or not.
- TID_EXE: input, [1:0]. Thread ID at EXE.
- mem_miss: input, 1 bit. The instruction fetch for thread TID_MEM missed.
- TID_MEM: input, [1:0]. Thread ID of the missing fetch.
- mem_fill: input, 1 bit. The miss of thread TID_FILL has been serviced.
- TID_FILL: input, [1:0]. Thread ID of the fill.
- TID_fetch: output, [1:0], registered. Thread selected for fetch in the current cycle.
- fetch_valid: output, 1 bit, registered. TID_fetch is meaningful. When it is 0, IF must not advance any PC.
- thread_ready: output, [N-1:0], combinational. Per-thread eligibility as defined under Operation.

## Operation
Per-thread state:
- br_pend[i]: thread i is waiting on a branch.
- mem_pend[i]: thread i is waiting on a memory fill.
- The block also keeps a round-robin pointer last_tid of 2 bits.

Pending-bit updates for thread i, applied at each rising edge:
- br_pend[i] next value = (br_pend[i] and not (EXE_br_resolve and TID_EXE==i)) or (ID_br_issue and TID_ID==i). If set and clear hit the same thread in the same cycle, set wins.
- mem_pend[i] is updated the same way: mem_miss / TID_MEM sets it, mem_fill / TID_FILL clears it, and set wins.
- Both bits are independent. A thread may wait on both at once.

Eligibility:
- thread_ready[i] = thread_en[i] and not br_pend[i] and not mem_pend[i] and not blk_now[i].
- blk_now[i] = (ID_br_issue and TID_ID==i) or (mem_miss and TID_MEM==i). A blocking event therefore removes the thread from selection in the cycle the event arrives.
- Wake events (resolve, fill) take effect only from the next cycle, through the pending bits.

Selection:
- The candidate order is last_tid+1, last_tid+2, last_tid+3, last_tid, all mod 4.
- The first candidate with thread_ready set is registered into TID_fetch, with fetch_valid=1, and last_tid takes that ID.
- If a single thread is ready, it is selected every cycle.
- If no thread is ready: fetch_valid=0, TID_fetch holds its previous value, and last_tid is unchanged.

Configuration and events:
- Clearing thread_en[i] does not clear pending bits. Events for disabled threads are still tracked.
- Wake events for a thread with no pending bit set have no effect. Duplicate blocks are idempotent.

## Timing
- Reset: TID_fetch=0, fetch_valid=0, br_pend and mem_pend all 0, last_tid=3. The first selection after reset is therefore thread 0.
- Latency: the selection computed in cycle t appears on TID_fetch/fetch_valid in cycle t+1.
- Block event in cycle t: the thread cannot appear on TID_fetch in cycle t+1 or later until it is woken.
- Wake event in cycle t: the pending bit clears at the edge ending t. The thread can first appear on TID_fetch in cycle t+2.
- Reset asserted mid-operation overrides all events in that cycle. The state of the following cycle equals the reset state.
- thread_ready has no registered delay with respect to its inputs.

## Test plan
- Reset, then thread_en=4'b1111 with no events: TID_fetch goes 0,1,2,3,0,... and fetch_valid=1 from the first cycle after reset is released.
- thread_en=4'b0101: TID_fetch alternates 0,2,0,2. Then set thread_en=4'b0000: fetch_valid=0 one cycle later and TID_fetch holds 2.
- ID_br_issue with TID_ID=1 in cycle t: thread 1 is absent from TID_fetch (sequence 0,2,3,0,...) until EXE_br_resolve with TID_EXE=1 in cycle u. Thread 1 reappears no earlier than cycle u+2, in its round-robin turn.
- mem_miss for thread 3 while br_pend[3]=1. Resolve the branch first: thread 3 stays parked. Then mem_fill for thread 3: thread 3 is eligible after 2 cycles.
- Same-cycle EXE_br_resolve for thread 2 and ID_br_issue for thread 2: br_pend[2] remains 1 and thread 2 is not selected.
- All four threads blocked: fetch_valid=0 and TID_fetch holds. Fill thread 2: TID_fetch=2 with fetch_valid=1 two cycles later. Assert rst mid-sequence: next cycle fetch_valid=0 and TID_fetch=0, then 0 is selected first.

Source files
------------

// File: rtl/thread_scheduler.sv
// Round-robin fetch scheduler for the interleaved multithreading front end.
// Parks threads with an unresolved branch or an outstanding I-fetch miss.
module thread_scheduler #(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] thread_en_i,
    input  logic         id_br_issue_i,
    input  logic [1:0]   tid_id_i,
    input  logic         exe_br_resolve_i,
    input  logic [1:0]   tid_exe_i,
    input  logic         mem_miss_i,
    input  logic [1:0]   tid_mem_i,
    input  logic         mem_fill_i,
    input  logic [1:0]   tid_fill_i,
    output logic [1:0]   tid_fetch_o,
    output logic         fetch_valid_o,
    output logic [N-1:0] thread_ready_o
);

    logic [N-1:0] br_pend_q, br_pend_d;
    logic [N-1:0] mem_pend_q, mem_pend_d;
    logic [N-1:0] blk_now;
    logic [1:0]   last_tid_q, last_tid_d;
    logic [1:0]   tid_fetch_q, tid_fetch_d;
    logic         fetch_valid_q, fetch_valid_d;

    // Pending bits: set wins over a same-cycle clear.
    always_comb begin
        br_pend_d  = br_pend_q;
        mem_pend_d = mem_pend_q;
        blk_now    = '0;
        for (int i = 0; i < N; i++) begin
            blk_now[i]    = (id_br_issue_i && tid_id_i == 2'(i)) ||
                            (mem_miss_i && tid_mem_i == 2'(i));
            br_pend_d[i]  = (br_pend_q[i] && !(exe_br_resolve_i && tid_exe_i == 2'(i))) ||
                            (id_br_issue_i && tid_id_i == 2'(i));
            mem_pend_d[i] = (mem_pend_q[i] && !(mem_fill_i && tid_fill_i == 2'(i))) ||
                            (mem_miss_i && tid_mem_i == 2'(i));
        end
    end

    assign thread_ready_o = thread_en_i & ~br_pend_q & ~mem_pend_q & ~blk_now;

    // Scan last_tid+1 .. last_tid+4 (wrapping), first ready thread wins.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        cand          = '0;
        found         = 1'b0;
        tid_fetch_d   = tid_fetch_q;
        fetch_valid_d = 1'b0;
        last_tid_d    = last_tid_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_tid_q + 2'(k);
            if (!found && thread_ready_o[cand]) begin
                found         = 1'b1;
                tid_fetch_d   = cand;
                fetch_valid_d = 1'b1;
                last_tid_d    = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_pend_q     <= '0;
            mem_pend_q    <= '0;
            last_tid_q    <= 2'd3;
            tid_fetch_q   <= 2'd0;
            fetch_valid_q <= 1'b0;
        end else begin
            br_pend_q     <= br_pend_d;
            mem_pend_q    <= mem_pend_d;
            last_tid_q    <= last_tid_d;
            tid_fetch_q   <= tid_fetch_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign tid_fetch_o   = tid_fetch_q;
    assign fetch_valid_o = fetch_valid_q;

endmodule
